rpc_reg_boot_seq: RTL



---
 rtl/rpc_reg_boot_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rpc_reg_boot_seq.sv
// Boot-time regbus master: writes a parameterised config table into the RPC DRAM
// controller after reset, then hands the port to the SoC host. Optional readback: RPC_BOOT_VERIFY_EN.
module rpc_reg_boot_seq #(
  parameter int                        NumEntries = 4,
  parameter logic [NumEntries*48-1:0]  InitAddr   = '0,
  parameter logic [NumEntries*32-1:0]  InitData   = '0,
  parameter logic [NumEntries*4-1:0]   InitStrb   = '1,
  parameter int                        StartDelay = 16,
  parameter int                        GapCycles  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        restart_i,
  input  logic [47:0] host_addr_i,
  input  logic        host_write_i,
  input  logic [31:0] host_wdata_i,
  input  logic [3:0]  host_wstrb_i,
  input  logic        host_valid_i,
  output logic [31:0] host_rdata_o,
  output logic        host_ready_o,
  output logic        host_error_o,
  output logic [47:0] dev_addr_o,
  output logic        dev_write_o,
  output logic [31:0] dev_wdata_o,
  output logic [3:0]  dev_wstrb_o,
  output logic        dev_valid_o,
  input  logic [31:0] dev_rdata_i,
  input  logic        dev_ready_i,
  input  logic        dev_error_i,
  output logic        boot_busy_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  localparam int IDX_W   = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int CNT_MAX = (StartDelay > GapCycles) ? StartDelay : GapCycles;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] START_LAST = (StartDelay > 0) ? CNT_W'(StartDelay - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST   = (GapCycles > 0)  ? CNT_W'(GapCycles - 1)  : '0;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NumEntries - 1);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_ACCESS = 3'd1,
`ifdef RPC_BOOT_VERIFY_EN
    ST_VERIFY = 3'd4,
`endif
    ST_GAP    = 3'd2,
    ST_HOST   = 3'd3
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             restart_pend;

  logic [47:0] dev_addr_q;
  logic        dev_write_q;
  logic [31:0] dev_wdata_q;
  logic [3:0]  dev_wstrb_q;
  logic        dev_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic [47:0] cur_addr, nxt_addr;
  logic [31:0] cur_data, nxt_data;
  logic [3:0]  cur_strb, nxt_strb;
  logic        entry_done;
  logic        in_host;

  assign nxt_idx = (idx == IDX_LAST) ? idx : idx + 1'b1;

  // Table lookup for the current entry (first load) and the following one.
  always_comb begin
    cur_addr = InitAddr[int'(idx) * 48 +: 48];
    cur_data = InitData[int'(idx) * 32 +: 32];
    cur_strb = InitStrb[int'(idx) * 4 +: 4];
    nxt_addr = InitAddr[int'(nxt_idx) * 48 +: 48];
    nxt_data = InitData[int'(nxt_idx) * 32 +: 32];
    nxt_strb = InitStrb[int'(nxt_idx) * 4 +: 4];
  end

`ifdef RPC_BOOT_VERIFY_EN
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  logic rd_mismatch;
  assign rd_mismatch = |((dev_rdata_i ^ dev_wdata_q) & strb_mask(dev_wstrb_q));
  assign entry_done  = (state == ST_VERIFY) && dev_ready_i;
`else
  assign entry_done  = (state == ST_ACCESS) && dev_ready_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_WAIT;
      cnt          <= '0;
      idx          <= '0;
      restart_pend <= 1'b0;
      dev_addr_q   <= '0;
      dev_write_q  <= 1'b0;
      dev_wdata_q  <= '0;
      dev_wstrb_q  <= '0;
      dev_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (StartDelay == 0 || cnt == START_LAST) begin
            cnt         <= '0;
            state       <= ST_ACCESS;
            dev_addr_q  <= cur_addr;
            dev_wdata_q <= cur_data;
            dev_wstrb_q <= cur_strb;
            dev_write_q <= 1'b1;
            dev_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACCESS: begin
          if (dev_ready_i) begin
            if (dev_error_i) err_q <= 1'b1;
`ifdef RPC_BOOT_VERIFY_EN
            // Write accepted: reissue the same address as a read for readback.
            state       <= ST_VERIFY;
            dev_write_q <= 1'b0;
`endif
          end
        end
`ifdef RPC_BOOT_VERIFY_EN
        ST_VERIFY: begin
          if (dev_ready_i && (dev_error_i || rd_mismatch)) err_q <= 1'b1;
        end
`endif
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt         <= '0;
            idx         <= nxt_idx;
            state       <= ST_ACCESS;
            dev_addr_q  <= nxt_addr;
            dev_wdata_q <= nxt_data;
            dev_wstrb_q <= nxt_strb;
            dev_write_q <= 1'b1;
            dev_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOST: begin
          // A restart is never allowed to cut an in-flight host transfer short.
          if (restart_i || restart_pend) begin
            if (host_valid_i) begin
              restart_pend <= 1'b1;
            end else begin
              restart_pend <= 1'b0;
              state        <= ST_WAIT;
              cnt          <= '0;
              idx          <= '0;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              err_q        <= 1'b0;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase

      // Completion of one table entry overrides the per-state updates above.
      if (entry_done) begin
        if (idx == IDX_LAST) begin
          state       <= ST_HOST;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          dev_valid_q <= 1'b0;
          dev_write_q <= 1'b0;
          dev_addr_q  <= '0;
          dev_wdata_q <= '0;
          dev_wstrb_q <= '0;
        end else if (GapCycles == 0) begin
          idx         <= nxt_idx;
          state       <= ST_ACCESS;
          dev_addr_q  <= nxt_addr;
          dev_wdata_q <= nxt_data;
          dev_wstrb_q <= nxt_strb;
          dev_write_q <= 1'b1;
          dev_valid_q <= 1'b1;
        end else begin
          state       <= ST_GAP;
          cnt         <= '0;
          dev_valid_q <= 1'b0;
          dev_write_q <= 1'b0;
        end
      end
    end
  end

  // Once booted the device port is a zero-latency wire to the host port.
  assign in_host = (state == ST_HOST);

  assign dev_addr_o   = in_host ? host_addr_i  : dev_addr_q;
  assign dev_write_o  = in_host ? host_write_i : dev_write_q;
  assign dev_wdata_o  = in_host ? host_wdata_i : dev_wdata_q;
  assign dev_wstrb_o  = in_host ? host_wstrb_i : dev_wstrb_q;
  assign dev_valid_o  = in_host ? host_valid_i : dev_valid_q;

  assign host_rdata_o = in_host ? dev_rdata_i  : '0;
  assign host_ready_o = in_host & dev_ready_i;
  assign host_error_o = in_host & dev_error_i;

  assign boot_busy_o  = busy_q;
  assign boot_done_o  = done_q;
  assign boot_err_o   = err_q;

endmodule
